// File: rtl/accelerator_package.sv
// Shared types for the Z tile store scheduler: pass parameters,
// streamer control bundle and scheduler FSM states.
package accelerator_package;

    localparam int unsigned ZT_ADDR_WIDTH = 32;
    localparam int unsigned ZT_CNT_WIDTH  = 16;

    typedef struct packed {
        logic [ZT_ADDR_WIDTH-1:0] base_address;
        logic [ZT_CNT_WIDTH-1:0]  x_rows;
        logic [ZT_CNT_WIDTH-1:0]  y_columns;
        logic [ZT_ADDR_WIDTH-1:0] row_stride;
    } Z_tile_param_t;

    typedef struct packed {
        logic                     req_start;
        logic [ZT_ADDR_WIDTH-1:0] base_addr;
        logic [ZT_ADDR_WIDTH-1:0] tot_len;
        logic [ZT_ADDR_WIDTH-1:0] d0_len;
        logic [ZT_ADDR_WIDTH-1:0] d0_stride;
        logic [ZT_ADDR_WIDTH-1:0] d1_len;
        logic [ZT_ADDR_WIDTH-1:0] d1_stride;
        logic [ZT_ADDR_WIDTH-1:0] d2_stride;
        logic [ZT_ADDR_WIDTH-1:0] d3_stride;
        logic [3:0]               dim_enable_1h;
    } hci_streamer_ctrl_t;

    typedef enum logic [1:0] {
        ZT_IDLE,
        ZT_ISSUE,
        ZT_WAIT,
        ZT_DONE
    } z_tile_state_e;

endpackage

// File: rtl/z_tile_counter.sv
// 2-D tile walker: (row, col) block indices, address offset accumulators,
// remaining-element counters for edge trimming and last-tile detection.
module z_tile_counter
    import accelerator_package::*;
#(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned Y_BLOCK_SIZE = 4,
    parameter int unsigned X_BLOCK_SIZE = 2,
    parameter int unsigned ADDR_WIDTH   = ZT_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH    = ZT_CNT_WIDTH,
    localparam int unsigned CW = $clog2(Y_BLOCK_SIZE) + 1,
    localparam int unsigned RW = $clog2(X_BLOCK_SIZE) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [CNT_WIDTH-1:0]  x_rows_i,
    input  logic [CNT_WIDTH-1:0]  y_columns_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    output logic [CNT_WIDTH-1:0]  row_idx_o,
    output logic [CNT_WIDTH-1:0]  col_idx_o,
    output logic [ADDR_WIDTH-1:0] offset_o,
    output logic [CW-1:0]         cols_o,
    output logic [RW-1:0]         rows_o,
    output logic                  last_o
);

    localparam int unsigned XSH = $clog2(X_BLOCK_SIZE);
    localparam int unsigned YSH = $clog2(Y_BLOCK_SIZE) + $clog2(DATA_SIZE / 8);
    localparam logic [CNT_WIDTH-1:0]  Y_BLK    = CNT_WIDTH'(Y_BLOCK_SIZE);
    localparam logic [CNT_WIDTH-1:0]  X_BLK    = CNT_WIDTH'(X_BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(1) << YSH;

    logic [CNT_WIDTH-1:0]  r_row_idx;
    logic [CNT_WIDTH-1:0]  r_col_idx;
    logic [CNT_WIDTH-1:0]  r_row_rem;
    logic [CNT_WIDTH-1:0]  r_col_rem;
    logic [CNT_WIDTH-1:0]  r_y_cols;
    logic [ADDR_WIDTH-1:0] r_row_step;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_col_off;

    logic w_last_col;
    logic w_last_row;

    assign w_last_col = (r_col_rem <= Y_BLK);
    assign w_last_row = (r_row_rem <= X_BLK);

    // Remaining counts hold the untrimmed distance to the matrix edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_row_idx  <= '0;
            r_col_idx  <= '0;
            r_row_rem  <= '0;
            r_col_rem  <= '0;
            r_y_cols   <= '0;
            r_row_step <= '0;
            r_row_base <= '0;
            r_col_off  <= '0;
        end else if (load_i) begin
            r_row_idx  <= '0;
            r_col_idx  <= '0;
            r_row_rem  <= x_rows_i;
            r_col_rem  <= y_columns_i;
            r_y_cols   <= y_columns_i;
            r_row_step <= row_stride_i << XSH;
            r_row_base <= '0;
            r_col_off  <= '0;
        end else if (step_i) begin
            if (w_last_col) begin
                r_col_idx  <= '0;
                r_col_rem  <= r_y_cols;
                r_col_off  <= '0;
                r_row_idx  <= r_row_idx + 1'b1;
                r_row_rem  <= r_row_rem - X_BLK;
                r_row_base <= r_row_base + r_row_step;
            end else begin
                r_col_idx  <= r_col_idx + 1'b1;
                r_col_rem  <= r_col_rem - Y_BLK;
                r_col_off  <= r_col_off + COL_STEP;
            end
        end
    end

    assign row_idx_o = r_row_idx;
    assign col_idx_o = r_col_idx;
    assign offset_o  = r_row_base + r_col_off;
    assign cols_o    = w_last_col ? r_col_rem[CW-1:0] : Y_BLK[CW-1:0];
    assign rows_o    = w_last_row ? r_row_rem[RW-1:0] : X_BLK[RW-1:0];
    assign last_o    = w_last_row & w_last_col;

endmodule

// File: rtl/z_tile_store_scheduler.sv
// Issues one Z store streamer configuration per 2-D tile of the output
// matrix, column blocks inner and row blocks outer, with run/done control.
module z_tile_store_scheduler
    import accelerator_package::*;
#(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned Y_BLOCK_SIZE = 4,
    parameter int unsigned X_BLOCK_SIZE = 2,
    parameter int unsigned ADDR_WIDTH   = ZT_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH    = ZT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  Z_tile_param_t        params_i,
    input  logic                 sched_proceed_i,
    output logic                 config_valid_o,
    input  logic                 config_ready_i,
    output hci_streamer_ctrl_t   config_o,
    output logic [CNT_WIDTH-1:0] tile_row_o,
    output logic [CNT_WIDTH-1:0] tile_col_o,
    output logic                 last_tile_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned CW = $clog2(Y_BLOCK_SIZE) + 1;
    localparam int unsigned RW = $clog2(X_BLOCK_SIZE) + 1;

    z_tile_state_e r_state;
    z_tile_state_e w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_stride;

    logic                  w_empty;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_step;
    logic [CNT_WIDTH-1:0]  w_row_idx;
    logic [CNT_WIDTH-1:0]  w_col_idx;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [CW-1:0]         w_cols;
    logic [RW-1:0]         w_rows;
    logic [CW+RW-1:0]      w_tot;
    logic                  w_last;
    logic                  w_active;

    assign w_empty  = (params_i.x_rows == '0) || (params_i.y_columns == '0);
    assign w_accept = (r_state == ZT_IDLE) && start_i && !clear_i;
    assign w_load   = w_accept && !w_empty;
    assign w_step   = (r_state == ZT_WAIT) && sched_proceed_i && !w_last;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ZT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ZT_IDLE: begin
                if (start_i) w_state_next = w_empty ? ZT_DONE : ZT_ISSUE;
            end
            ZT_ISSUE: begin
                if (config_ready_i) w_state_next = ZT_WAIT;
            end
            ZT_WAIT: begin
                if (sched_proceed_i) w_state_next = w_last ? ZT_DONE : ZT_ISSUE;
            end
            ZT_DONE: w_state_next = ZT_IDLE;
            default: w_state_next = ZT_IDLE;
        endcase
        if (clear_i) w_state_next = ZT_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_base   <= '0;
            r_stride <= '0;
        end else if (w_accept) begin
            r_base   <= params_i.base_address;
            r_stride <= params_i.row_stride;
        end
    end

    z_tile_counter #(
        .DATA_SIZE    (DATA_SIZE),
        .Y_BLOCK_SIZE (Y_BLOCK_SIZE),
        .X_BLOCK_SIZE (X_BLOCK_SIZE),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .load_i       (w_load),
        .step_i       (w_step),
        .x_rows_i     (params_i.x_rows),
        .y_columns_i  (params_i.y_columns),
        .row_stride_i (params_i.row_stride),
        .row_idx_o    (w_row_idx),
        .col_idx_o    (w_col_idx),
        .offset_o     (w_offset),
        .cols_o       (w_cols),
        .rows_o       (w_rows),
        .last_o       (w_last)
    );

    // Edge tiles are at most Y x X, so this product stays narrow
    assign w_tot    = {{RW{1'b0}}, w_cols} * {{CW{1'b0}}, w_rows};
    assign w_active = (r_state == ZT_ISSUE) || (r_state == ZT_WAIT);

    always_comb begin
        config_o       = '0;
        config_valid_o = (r_state == ZT_ISSUE);
        busy_o         = (r_state != ZT_IDLE);
        done_o         = (r_state == ZT_DONE);
        tile_row_o     = '0;
        tile_col_o     = '0;
        last_tile_o    = 1'b0;
        if (w_active) begin
            config_o.req_start     = 1'b1;
            config_o.base_addr     = r_base + w_offset;
            config_o.tot_len       = ZT_ADDR_WIDTH'(w_tot);
            config_o.d0_len        = ZT_ADDR_WIDTH'(w_cols);
            config_o.d0_stride     = ZT_ADDR_WIDTH'(DATA_SIZE / 8);
            config_o.d1_len        = ZT_ADDR_WIDTH'(w_rows);
            config_o.d1_stride     = r_stride;
            config_o.dim_enable_1h = (w_rows > RW'(1)) ? 4'b0001 : 4'b0000;
            tile_row_o             = w_row_idx;
            tile_col_o             = w_col_idx;
            last_tile_o            = w_last;
        end
    end

endmodule

// File: tb/tb_z_tile_store_scheduler.sv
// Scoreboard bench for z_tile_store_scheduler: reference tile list is
// pushed at start, popped and compared on every config transfer.
module tb_z_tile_store_scheduler;
    import accelerator_package::*;

    localparam int unsigned DS = 32;
    localparam int unsigned YB = 4;
    localparam int unsigned XB = 2;

    typedef struct packed {
        hci_streamer_ctrl_t cfg;
        logic [15:0]        row;
        logic [15:0]        col;
        logic               last;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               clear_i;
    logic               start_i;
    Z_tile_param_t      params_i;
    logic               sched_proceed_i;
    logic               config_valid_o;
    logic               config_ready_i;
    hci_streamer_ctrl_t config_o;
    logic [15:0]        tile_row_o;
    logic [15:0]        tile_col_o;
    logic               last_tile_o;
    logic               busy_o;
    logic               done_o;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];

    z_tile_store_scheduler #(
        .DATA_SIZE    (DS),
        .Y_BLOCK_SIZE (YB),
        .X_BLOCK_SIZE (XB),
        .ADDR_WIDTH   (32),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .params_i        (params_i),
        .sched_proceed_i (sched_proceed_i),
        .config_valid_o  (config_valid_o),
        .config_ready_i  (config_ready_i),
        .config_o        (config_o),
        .tile_row_o      (tile_row_o),
        .tile_col_o      (tile_col_o),
        .last_tile_o     (last_tile_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Every accepted transfer must match the next expected tile
    always @(negedge clk_i) begin
        if (rst_ni && config_valid_o && config_ready_i) begin
            exp_t e;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_transfer: got base=%h want no request",
                         config_o.base_addr);
            end else begin
                e = sb.pop_front();
                if ({config_o, tile_row_o, tile_col_o, last_tile_o} !== e) begin
                    $display("FAIL tile_r%0d_c%0d: got cfg=%h r=%0d c=%0d last=%0b want cfg=%h r=%0d c=%0d last=%0b",
                             e.row, e.col, config_o, tile_row_o, tile_col_o,
                             last_tile_o, e.cfg, e.row, e.col, e.last);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_pass(input logic [31:0] b, input int xr,
                             input int yc, input logic [31:0] st);
        int nr;
        int nc;
        nr = (xr + XB - 1) / XB;
        nc = (yc + YB - 1) / YB;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                exp_t e;
                int   cols;
                int   rows;
                cols = (yc - c * YB) < YB ? (yc - c * YB) : YB;
                rows = (xr - r * XB) < XB ? (xr - r * XB) : XB;
                e = '0;
                e.cfg.req_start     = 1'b1;
                e.cfg.base_addr     = b + 32'(r * XB) * st + 32'(c * YB * (DS / 8));
                e.cfg.tot_len       = 32'(cols * rows);
                e.cfg.d0_len        = 32'(cols);
                e.cfg.d0_stride     = 32'(DS / 8);
                e.cfg.d1_len        = 32'(rows);
                e.cfg.d1_stride     = st;
                e.cfg.dim_enable_1h = (rows > 1) ? 4'b0001 : 4'b0000;
                e.row  = 16'(r);
                e.col  = 16'(c);
                e.last = (r == nr - 1) && (c == nc - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_pass(input logic [31:0] b, input logic [15:0] xr,
                              input logic [15:0] yc, input logic [31:0] st);
        params_i = '{base_address: b, x_rows: xr, y_columns: yc, row_stride: st};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_pass(input int lat, output int n_done, output bit tmo);
        int cyc;
        n_done = 0;
        tmo    = 1'b1;
        cyc    = 0;
        while (cyc < 300) begin
            if (done_o) n_done++;
            if (!busy_o) begin
                tmo = 1'b0;
                break;
            end
            if (config_valid_o) begin
                repeat (lat) tick();
                config_ready_i = 1'b1;
                tick();
                config_ready_i = 1'b0;
                tick();
                sched_proceed_i = 1'b1;
                tick();
                sched_proceed_i = 1'b0;
                cyc += 3 + lat;
            end else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b1;
        sched_proceed_i = 1'b0;
        config_ready_i = 1'b0;
        params_i = '{base_address: 32'h55, x_rows: 16'd4, y_columns: 16'd4, row_stride: 32'd8};
        repeat (3) tick();
        n_total++;
        if ({config_valid_o, busy_o, done_o} !== 3'b000)
            $display("FAIL reset_ctrl: got v/b/d=%b want 000", {config_valid_o, busy_o, done_o});
        else n_pass++;
        n_total++;
        if (config_o !== '0) $display("FAIL reset_cfg: got %h want 0", config_o);
        else n_pass++;
        n_total++;
        if ({tile_row_o, tile_col_o, last_tile_o} !== 33'd0)
            $display("FAIL reset_tile: got r=%0d c=%0d l=%0b want 0", tile_row_o, tile_col_o, last_tile_o);
        else n_pass++;
        start_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL reset_idle: got busy=%0b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_full_tiles();
        int n_done;
        bit tmo;
        push_pass(32'h100, 4, 8, 32'd32);
        start_pass(32'h100, 16'd4, 16'd8, 32'd32);
        n_total++;
        if (config_valid_o !== 1'b1) $display("FAIL full_latency: got valid=%0b want 1", config_valid_o);
        else n_pass++;
        run_pass(0, n_done, tmo);
        n_total++;
        if (tmo !== 1'b0 || n_done !== 1)
            $display("FAIL full_done: got done=%0d tmo=%0b want done=1 tmo=0", n_done, tmo);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL full_count: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_edge_tiles();
        int n_done;
        bit tmo;
        push_pass(32'h200, 3, 6, 32'd24);
        start_pass(32'h200, 16'd3, 16'd6, 32'd24);
        run_pass(1, n_done, tmo);
        n_total++;
        if (tmo !== 1'b0 || n_done !== 1)
            $display("FAIL edge_done: got done=%0d tmo=%0b want done=1 tmo=0", n_done, tmo);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL edge_count: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        push_pass(32'h0, 2, 4, 32'd16);
        start_pass(32'h0, 16'd2, 16'd4, 32'd16);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (config_valid_o !== 1'b1 || config_o !== sb[0].cfg) bad++;
            tick();
        end
        n_total++;
        if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
        else n_pass++;
        config_ready_i = 1'b1;
        tick();
        config_ready_i = 1'b0;
        n_total++;
        if (config_valid_o !== 1'b0 || sb.size() !== 0)
            $display("FAIL bp_single: got valid=%0b pending=%0d want 0/0", config_valid_o, sb.size());
        else n_pass++;
        sched_proceed_i = 1'b1;
        tick();
        sched_proceed_i = 1'b0;
        n_total++;
        if (done_o !== 1'b1) $display("FAIL bp_done: got %0b want 1", done_o);
        else n_pass++;
        tick();
        n_total++;
        if ({busy_o, done_o} !== 2'b00) $display("FAIL bp_idle: got b/d=%b want 00", {busy_o, done_o});
        else n_pass++;
    endtask

    task automatic test_zero_dims();
        config_ready_i = 1'b1;
        start_pass(32'h80, 16'd4, 16'd0, 32'd16);
        n_total++;
        if ({config_valid_o, done_o, busy_o} !== 3'b011)
            $display("FAIL zero_t1: got v/d/b=%b want 011", {config_valid_o, done_o, busy_o});
        else n_pass++;
        tick();
        config_ready_i = 1'b0;
        n_total++;
        if ({config_valid_o, done_o, busy_o} !== 3'b000)
            $display("FAIL zero_t2: got v/d/b=%b want 000", {config_valid_o, done_o, busy_o});
        else n_pass++;
    endtask

    task automatic test_clear();
        int n_done;
        bit tmo;
        push_pass(32'h300, 4, 8, 32'd32);
        start_pass(32'h300, 16'd4, 16'd8, 32'd32);
        config_ready_i = 1'b1;
        tick();
        config_ready_i = 1'b0;
        sched_proceed_i = 1'b1;
        tick();
        sched_proceed_i = 1'b0;
        config_ready_i = 1'b1;
        tick();
        config_ready_i = 1'b0;
        clear_i = 1'b1;
        sched_proceed_i = 1'b1;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        sched_proceed_i = 1'b0;
        start_i = 1'b0;
        n_total++;
        if ({busy_o, config_valid_o, done_o} !== 3'b000)
            $display("FAIL clr_idle: got b/v/d=%b want 000", {busy_o, config_valid_o, done_o});
        else n_pass++;
        tick();
        n_total++;
        if ({busy_o, done_o} !== 2'b00) $display("FAIL clr_nodone: got b/d=%b want 00", {busy_o, done_o});
        else n_pass++;
        n_total++;
        if (sb.size() !== 2) $display("FAIL clr_count: got %0d pending want 2", sb.size());
        else n_pass++;
        sb.delete();
        push_pass(32'h300, 4, 8, 32'd32);
        start_pass(32'h300, 16'd4, 16'd8, 32'd32);
        n_total++;
        if ({tile_row_o, tile_col_o} !== {sb[0].row, sb[0].col})
            $display("FAIL clr_restart: got r=%0d c=%0d want r=0 c=0", tile_row_o, tile_col_o);
        else n_pass++;
        run_pass(0, n_done, tmo);
        n_total++;
        if (tmo !== 1'b0 || n_done !== 1 || sb.size() !== 0)
            $display("FAIL clr_rerun: got done=%0d tmo=%0b pending=%0d want 1/0/0", n_done, tmo, sb.size());
        else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        int n_done;
        bit tmo;
        push_pass(32'h400, 4, 8, 32'd32);
        start_pass(32'h400, 16'd4, 16'd8, 32'd32);
        params_i = '{base_address: 32'hdead0, x_rows: 16'd1, y_columns: 16'd1, row_stride: 32'd4};
        start_i = 1'b1;
        sched_proceed_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        sched_proceed_i = 1'b0;
        n_total++;
        if (config_valid_o !== 1'b1 || config_o !== sb[0].cfg || tile_col_o !== sb[0].col)
            $display("FAIL ign_issue: got v=%0b base=%h c=%0d want v=1 base=%h c=0",
                     config_valid_o, config_o.base_addr, tile_col_o, sb[0].cfg.base_addr);
        else n_pass++;
        run_pass(2, n_done, tmo);
        n_total++;
        if (tmo !== 1'b0 || n_done !== 1 || sb.size() !== 0)
            $display("FAIL ign_pass: got done=%0d tmo=%0b pending=%0d want 1/0/0", n_done, tmo, sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_tiles();
        test_edge_tiles();
        test_backpressure();
        test_zero_dims();
        test_clear();
        test_ignored_inputs();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
